// File: rtl/conv_mac_core.sv
// Sequential 1-D convolution engine: Z[n] = sum_k X[k]*Y[n-k], unsigned, saturating output.
// Latency: T(n)+2 cycles per result (T MAC issues, 1 drain, 1 write); done one cycle after last write.
// Backpressure: none; start is accepted only in IDLE, memories are fixed one-cycle synchronous reads.
module conv_mac_core #(
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 16,
    parameter int ADDR_X_W = 5,
    parameter int ADDR_Y_W = 5,
    parameter int ADDR_Z_W = 6,
    parameter int ACC_W    = 21
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [ADDR_X_W-1:0] sizeX,
    input  logic [ADDR_Y_W-1:0] sizeY,
    output logic [ADDR_X_W-1:0] memX_addr,
    input  logic [DATA_W-1:0]   dataX,
    output logic [ADDR_Y_W-1:0] memY_addr,
    input  logic [DATA_W-1:0]   dataY,
    output logic [ADDR_Z_W-1:0] memZ_addr,
    output logic [OUT_W-1:0]    dataZ,
    output logic                writeZ,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, FIN} state_t;

    localparam logic [ADDR_Z_W-1:0] ONE_Z = ADDR_Z_W'(1);
    localparam logic [ADDR_Z_W-1:0] TWO_Z = ADDR_Z_W'(2);
    localparam logic [ADDR_X_W-1:0] ONE_X = ADDR_X_W'(1);
    localparam logic [ACC_W-1:0]    SAT_MAX = ACC_W'({OUT_W{1'b1}});

    state_t              state;
    logic [ADDR_X_W-1:0] size_x_q;
    logic [ADDR_Y_W-1:0] size_y_q;
    logic [ADDR_Z_W-1:0] n;
    logic [ADDR_X_W-1:0] k;
    logic [ACC_W-1:0]    acc;
    logic                issue_vld;

    logic [ADDR_Z_W-1:0] size_x_ext;
    logic [ADDR_Z_W-1:0] size_y_ext;
    logic [ADDR_Z_W-1:0] n_next;
    logic [ADDR_Z_W-1:0] k_ext;
    logic [ADDR_Z_W-1:0] k_max;
    logic [ADDR_Z_W-1:0] kmin_next;
    logic [ADDR_Z_W-1:0] n_last;
    logic [ADDR_X_W-1:0] k_inc;
    logic [ADDR_Z_W-1:0] y_inc;
    logic [ADDR_Z_W-1:0] y_first;
    logic [ACC_W-1:0]    prod;
    logic [ACC_W-1:0]    acc_sum;
    logic [OUT_W-1:0]    acc_sat;

    // Index bounds for the current/next output sample and the MAC datapath.
    // n-k stays within 0..sizeY-1 because k is always clamped to [kmin, kmax].
    always_comb begin
        size_x_ext = ADDR_Z_W'(size_x_q);
        size_y_ext = ADDR_Z_W'(size_y_q);
        n_next     = n + ONE_Z;
        k_ext      = ADDR_Z_W'(k);
        k_max      = (n < size_x_ext) ? n : (size_x_ext - ONE_Z);
        kmin_next  = (n_next >= size_y_ext) ? (n_next - size_y_ext + ONE_Z) : '0;
        n_last     = size_x_ext + size_y_ext - TWO_Z;
        k_inc      = k + ONE_X;
        y_inc      = n - ADDR_Z_W'(k_inc);
        y_first    = n_next - kmin_next;
        prod       = ACC_W'(dataX) * ACC_W'(dataY);
        acc_sum    = acc + prod;
        acc_sat    = (acc_sum > SAT_MAX) ? {OUT_W{1'b1}} : acc_sum[OUT_W-1:0];
    end

    // Control FSM with registered memory addresses, write strobe and status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            size_x_q  <= '0;
            size_y_q  <= '0;
            n         <= '0;
            k         <= '0;
            acc       <= '0;
            issue_vld <= 1'b0;
            memX_addr <= '0;
            memY_addr <= '0;
            memZ_addr <= '0;
            dataZ     <= '0;
            writeZ    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            writeZ    <= 1'b0;
            done      <= 1'b0;
            // An address pair issued this cycle returns data next cycle.
            issue_vld <= (state == MAC);
            case (state)
                IDLE: begin
                    if (start) begin
                        size_x_q <= sizeX;
                        size_y_q <= sizeY;
                        acc      <= '0;
                        n        <= '0;
                        if (sizeX == '0 || sizeY == '0) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= MAC;
                            busy      <= 1'b1;
                            k         <= '0;
                            memX_addr <= '0;
                            memY_addr <= '0;
                        end
                    end
                end
                MAC: begin
                    if (issue_vld) begin
                        acc <= acc_sum;
                    end
                    if (k_ext == k_max) begin
                        state <= DRAIN;
                    end else begin
                        k         <= k_inc;
                        memX_addr <= k_inc;
                        memY_addr <= ADDR_Y_W'(y_inc);
                    end
                end
                DRAIN: begin
                    // Fold in the last product and present the saturated result.
                    acc       <= acc_sum;
                    dataZ     <= acc_sat;
                    memZ_addr <= n;
                    writeZ    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    acc <= '0;
                    if (n == n_last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= MAC;
                        n         <= n_next;
                        k         <= ADDR_X_W'(kmin_next);
                        memX_addr <= ADDR_X_W'(kmin_next);
                        memY_addr <= ADDR_Y_W'(y_first);
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_core.sv
// Directed bench for conv_mac_core with synchronous-read X/Y memory models.
// Latency: outputs sampled on the falling edge; cycle numbers counted from the start sampling edge.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_conv_mac_core;

    localparam int DW = 8, OW = 16, AXW = 5, AYW = 5, AZW = 6, ACCW = 21;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [AXW-1:0] sizeX = '0;
    logic [AYW-1:0] sizeY = '0;
    logic [AXW-1:0] memX_addr;
    logic [DW-1:0]  dataX = '0;
    logic [AYW-1:0] memY_addr;
    logic [DW-1:0]  dataY = '0;
    logic [AZW-1:0] memZ_addr;
    logic [OW-1:0]  dataZ;
    logic           writeZ;
    logic           busy;
    logic           done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    logic [DW-1:0] memx [0:31];
    logic [DW-1:0] memy [0:31];

    int wa[$];
    int wd[$];
    int wc[$];
    int done_total = 0;
    int done_cyc = 0;

    conv_mac_core #(
        .DATA_W(DW), .OUT_W(OW), .ADDR_X_W(AXW), .ADDR_Y_W(AYW),
        .ADDR_Z_W(AZW), .ACC_W(ACCW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .sizeX(sizeX), .sizeY(sizeY),
        .memX_addr(memX_addr), .dataX(dataX), .memY_addr(memY_addr), .dataY(dataY),
        .memZ_addr(memZ_addr), .dataZ(dataZ), .writeZ(writeZ), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data one cycle after the address.
    always @(posedge clk) begin
        dataX <= memx[memX_addr];
        dataY <= memy[memY_addr];
        cyc   <= cyc + 1;
    end

    // Log every write and done pulse with its cycle number.
    always @(negedge clk) begin
        if (writeZ === 1'b1) begin
            wa.push_back(int'(memZ_addr));
            wd.push_back(int'(dataZ));
            wc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_total = done_total + 1;
            done_cyc   = cyc;
        end
    end

    task automatic start_run(input logic [4:0] sx, input logic [4:0] sy, output int s_cyc);
        @(negedge clk);
        sizeX = sx;
        sizeY = sy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_cyc = cyc - 1;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int waited = 0;
        while (done_total == base && waited < budget) begin
            @(negedge clk);
            #1;
            waited++;
        end
        vec_cnt++;
        if (done_total == base) begin
            err_cnt++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic load_3x2();
        for (int i = 0; i < 32; i++) begin
            memx[i] = '0;
            memy[i] = '0;
        end
        memx[0] = 8'd1; memx[1] = 8'd2; memx[2] = 8'd3;
        memy[0] = 8'd4; memy[1] = 8'd5;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec_cnt++; if (memX_addr !== '0) begin err_cnt++; $display("FAIL rst_memX_addr: got %0d expected 0", memX_addr); end
        vec_cnt++; if (memY_addr !== '0) begin err_cnt++; $display("FAIL rst_memY_addr: got %0d expected 0", memY_addr); end
        vec_cnt++; if (memZ_addr !== '0) begin err_cnt++; $display("FAIL rst_memZ_addr: got %0d expected 0", memZ_addr); end
        vec_cnt++; if (dataZ !== '0) begin err_cnt++; $display("FAIL rst_dataZ: got %0d expected 0", dataZ); end
        vec_cnt++; if (writeZ !== 1'b0) begin err_cnt++; $display("FAIL rst_writeZ: got %b expected 0", writeZ); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b expected 0", done); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_3x2();
        int exp_d[4] = '{4, 13, 22, 15};
        int bw, bd, s;
        load_3x2();
        bw = wa.size();
        bd = done_total;
        start_run(5'd3, 5'd2, s);
        wait_done(bd, 100, "basic");
        vec_cnt++; if (wa.size() - bw != 4) begin err_cnt++; $display("FAIL basic_count: got %0d writes expected 4", wa.size() - bw); end
        for (int i = 0; i < 4; i++) begin
            if (bw + i < wa.size()) begin
                vec_cnt++; if (wa[bw+i] != i) begin err_cnt++; $display("FAIL basic_addr%0d: got %0d expected %0d", i, wa[bw+i], i); end
                vec_cnt++; if (wd[bw+i] != exp_d[i]) begin err_cnt++; $display("FAIL basic_data%0d: got %0d expected %0d", i, wd[bw+i], exp_d[i]); end
            end
        end
        vec_cnt++; if (done_total - bd != 1) begin err_cnt++; $display("FAIL basic_done: got %0d pulses expected 1", done_total - bd); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int bw;
        for (int i = 0; i < 32; i++) begin
            memx[i] = '0;
            memy[i] = '0;
        end
        memx[0] = 8'd7;
        memy[0] = 8'd9;
        bw = wa.size();
        @(negedge clk);
        sizeX = 5'd1;
        sizeY = 5'd1;
        start = 1'b1;
        for (int rel = 1; rel <= 5; rel++) begin
            @(negedge clk);
            start = 1'b0;
            vec_cnt++; if (busy !== (rel <= 3)) begin err_cnt++; $display("FAIL single_busy_c%0d: got %b expected %b", rel, busy, rel <= 3); end
            vec_cnt++; if (writeZ !== (rel == 3)) begin err_cnt++; $display("FAIL single_writeZ_c%0d: got %b expected %b", rel, writeZ, rel == 3); end
            vec_cnt++; if (done !== (rel == 4)) begin err_cnt++; $display("FAIL single_done_c%0d: got %b expected %b", rel, done, rel == 4); end
        end
        #1;
        vec_cnt++; if (wa.size() - bw != 1) begin err_cnt++; $display("FAIL single_count: got %0d writes expected 1", wa.size() - bw); end
        if (wa.size() > bw) begin
            vec_cnt++; if (wa[bw] != 0) begin err_cnt++; $display("FAIL single_addr: got %0d expected 0", wa[bw]); end
            vec_cnt++; if (wd[bw] != 63) begin err_cnt++; $display("FAIL single_data: got %0d expected 63", wd[bw]); end
        end
    endtask

    task automatic test_max();
        int bw, bd, s;
        for (int i = 0; i < 32; i++) begin
            memx[i] = 8'hFF;
            memy[i] = 8'hFF;
        end
        bw = wa.size();
        bd = done_total;
        start_run(5'd31, 5'd31, s);
        wait_done(bd, 3000, "max");
        vec_cnt++; if (wa.size() - bw != 61) begin err_cnt++; $display("FAIL max_count: got %0d writes expected 61", wa.size() - bw); end
        if (wa.size() - bw == 61) begin
            vec_cnt++; if (wd[bw] != 16'hFE01) begin err_cnt++; $display("FAIL max_z0: got %h expected fe01", wd[bw]); end
            vec_cnt++; if (wd[bw+1] != 16'hFFFF) begin err_cnt++; $display("FAIL max_z1: got %h expected ffff", wd[bw+1]); end
            vec_cnt++; if (wd[bw+30] != 16'hFFFF) begin err_cnt++; $display("FAIL max_z30: got %h expected ffff", wd[bw+30]); end
            vec_cnt++; if (wd[bw+60] != 16'hFE01) begin err_cnt++; $display("FAIL max_z60: got %h expected fe01", wd[bw+60]); end
            vec_cnt++; if (wa[bw+60] != 60) begin err_cnt++; $display("FAIL max_last_addr: got %0d expected 60", wa[bw+60]); end
            for (int i = 0; i < 61; i++) begin
                vec_cnt++; if (wa[bw+i] != i) begin err_cnt++; $display("FAIL max_addr%0d: got %0d expected %0d", i, wa[bw+i], i); end
            end
        end
        vec_cnt++; if (done_cyc - wc[wc.size()-1] != 1) begin err_cnt++; $display("FAIL max_done_gap: got %0d expected 1", done_cyc - wc[wc.size()-1]); end
    endtask

    task automatic test_zero_size();
        int bw, bd, s;
        bw = wa.size();
        bd = done_total;
        start_run(5'd4, 5'd0, s);
        wait_done(bd, 20, "zero");
        repeat (3) @(negedge clk);
        #1;
        vec_cnt++; if (wa.size() != bw) begin err_cnt++; $display("FAIL zero_writes: got %0d expected 0", wa.size() - bw); end
        vec_cnt++; if (done_total - bd != 1) begin err_cnt++; $display("FAIL zero_done_count: got %0d expected 1", done_total - bd); end
        vec_cnt++; if (done_cyc - s != 1) begin err_cnt++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc - s); end
    endtask

    task automatic test_back_to_back();
        int bd;
        bd = done_total;
        @(negedge clk);
        sizeX = 5'd4;
        sizeY = 5'd0;
        start = 1'b1;
        // Start is held across IDLE, FIN and the following IDLE edge.
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        vec_cnt++; if (done_total - bd != 2) begin err_cnt++; $display("FAIL b2b_done_count: got %0d expected 2", done_total - bd); end
    endtask

    task automatic test_restart_ignored();
        int exp_d[4] = '{4, 13, 22, 15};
        int bw, bd, s;
        load_3x2();
        bw = wa.size();
        bd = done_total;
        start_run(5'd3, 5'd2, s);
        repeat (3) @(negedge clk);
        sizeX = 5'd1;
        sizeY = 5'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bd, 100, "restart");
        repeat (3) @(negedge clk);
        #1;
        vec_cnt++; if (wa.size() - bw != 4) begin err_cnt++; $display("FAIL restart_count: got %0d writes expected 4", wa.size() - bw); end
        for (int i = 0; i < 4; i++) begin
            if (bw + i < wa.size()) begin
                vec_cnt++; if (wa[bw+i] != i) begin err_cnt++; $display("FAIL restart_addr%0d: got %0d expected %0d", i, wa[bw+i], i); end
                vec_cnt++; if (wd[bw+i] != exp_d[i]) begin err_cnt++; $display("FAIL restart_data%0d: got %0d expected %0d", i, wd[bw+i], exp_d[i]); end
            end
        end
        vec_cnt++; if (done_total - bd != 1) begin err_cnt++; $display("FAIL restart_done: got %0d pulses expected 1", done_total - bd); end
    endtask

    task automatic test_reset_mid();
        int exp_d[4] = '{4, 13, 22, 15};
        int bw, bd, s, waited, wcount;
        bit hit;
        for (int i = 0; i < 32; i++) begin
            memx[i] = 8'hFF;
            memy[i] = 8'hFF;
        end
        bd = done_total;
        start_run(5'd31, 5'd31, s);
        hit = 1'b0;
        waited = 0;
        while (!hit && waited < 300) begin
            @(negedge clk);
            waited++;
            if (writeZ === 1'b1 && memZ_addr == 6'd4) hit = 1'b1;
        end
        vec_cnt++; if (!hit) begin err_cnt++; $display("FAIL rmid_find_write5: got none expected write at addr 4"); end
        rstn = 1'b0;
        #1;
        vec_cnt++;
        if ({memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done} !== '0) begin
            err_cnt++;
            $display("FAIL rmid_outputs: got %h expected 0", {memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done});
        end
        wcount = wa.size();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        vec_cnt++; if (wa.size() != wcount) begin err_cnt++; $display("FAIL rmid_extra_writes: got %0d expected 0", wa.size() - wcount); end
        vec_cnt++; if (done_total != bd) begin err_cnt++; $display("FAIL rmid_done: got %0d pulses expected 0", done_total - bd); end
        load_3x2();
        bw = wa.size();
        bd = done_total;
        start_run(5'd3, 5'd2, s);
        wait_done(bd, 100, "rmid_rerun");
        vec_cnt++; if (wa.size() - bw != 4) begin err_cnt++; $display("FAIL rmid_rerun_count: got %0d writes expected 4", wa.size() - bw); end
        for (int i = 0; i < 4; i++) begin
            if (bw + i < wa.size()) begin
                vec_cnt++; if (wa[bw+i] != i) begin err_cnt++; $display("FAIL rmid_addr%0d: got %0d expected %0d", i, wa[bw+i], i); end
                vec_cnt++; if (wd[bw+i] != exp_d[i]) begin err_cnt++; $display("FAIL rmid_data%0d: got %0d expected %0d", i, wd[bw+i], exp_d[i]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            memx[i] = '0;
            memy[i] = '0;
        end
        test_reset();
        test_basic_3x2();
        test_single();
        test_max();
        test_zero_size();
        test_back_to_back();
        test_restart_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/conv_mac_core.md
Name: conv_mac_core

Overview:
- Sequential 1-D convolution engine, Z = X * Y, sitting directly downstream of the AIP interface in the convolution coprocessor.
- Reads kernel X and signal Y from the AIP input memories through synchronous read ports, and writes each result Z[n] to the AIP output memory.
- Reports busy as status and a done pulse as the interrupt source.
- Z[n] = sum over k of X[k]*Y[n-k], for n = 0 .. sizeX+sizeY-2.
- All arithmetic is unsigned.

Parameters:
- DATA_W, 8: width of X and Y samples.
- OUT_W, 16: width of Z results.
- ADDR_X_W, 5: kernel memory address width; max sizeX = 31.
- ADDR_Y_W, 5: signal memory address width; max sizeY = 31.
- ADDR_Z_W, 6: output memory address width.
- ACC_W, 21: internal accumulator width; must be >= 2*DATA_W + ADDR_X_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start request; sampled only in IDLE.
- sizeX  in  ADDR_X_W  kernel length; latched at start.
- sizeY  in  ADDR_Y_W  signal length; latched at start.
- memX_addr  out  ADDR_X_W  kernel read address.
- dataX  in  DATA_W  kernel read data; valid one cycle after memX_addr.
- memY_addr  out  ADDR_Y_W  signal read address.
- dataY  in  DATA_W  signal read data; valid one cycle after memY_addr.
- memZ_addr  out  ADDR_Z_W  result write address.
- dataZ  out  OUT_W  result write data.
- writeZ  out  1  result write enable; one cycle per result.
- busy  out  1  high while a convolution is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:

Reset:
- rstn low asynchronously forces state = IDLE.
- All outputs go to 0: memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done.
- Accumulator, n counter, k counter and latched sizes also clear to 0.
- Reset mid-operation abandons the run with no further writes and no done pulse.

State machine: IDLE, MAC, DRAIN, WRITE, FIN.
- IDLE:
  - On start=1: latch sizeX/sizeY, clear the accumulator, set n=0.
  - If either size = 0, go to FIN; otherwise set k = kmin(0) and go to MAC.
  - busy rises on the cycle after start is sampled.
- MAC:
  - Each cycle drive memX_addr=k and memY_addr=n-k.
  - Each cycle, accumulate the product of the data returned for the previous cycle's addresses, when that issue was valid.
  - kmin(n) = max(0, n-sizeY+1); kmax(n) = min(n, sizeX-1); term count T(n) = kmax-kmin+1 >= 1.
  - When k = kmax, go to DRAIN.
- DRAIN: accumulate the final product, then go to WRITE.
- WRITE:
  - Drive writeZ=1, memZ_addr=n, dataZ = min(acc, 2^OUT_W-1) (saturating, never wraps).
  - Clear the accumulator.
  - If n = sizeX+sizeY-2, go to FIN; otherwise set n=n+1, k=kmin(n+1) and go to MAC.
- FIN: done=1 for exactly this cycle, busy=0 from this cycle, go to IDLE.

Outputs outside the active states:
- writeZ=0 in every state except WRITE.
- dataZ and memZ_addr hold their last values outside WRITE.

Latency:
- Result n costs T(n)+2 cycles: T(n) MAC cycles, 1 DRAIN, 1 WRITE.
- done follows the last write by 1 cycle.
- Example: sizeX=sizeY=1 with start sampled at cycle 0 gives MAC at 1, DRAIN at 2, WRITE at 3, done at 4.

Boundary conditions:
- start while busy is ignored; sizeX/sizeY changes mid-run are ignored.
- start asserted in the FIN cycle is ignored; start in the following IDLE cycle is accepted.
- Maximum run, 31 x 31, produces 61 results at addresses 0..60; the address never wraps.
- Address arithmetic n-k never underflows because k is bounded by kmin/kmax.
- The accumulator never overflows internally: the maximum sum is 31*255*255 < 2^21.
- Saturation applies only at the output.

Test Plan:
- X={1,2,3}, sizeX=3, Y={4,5}, sizeY=2, start pulse -> writes (addr,data) = (0,4), (1,13), (2,22), (3,15); one done pulse; busy low after.
- sizeX=sizeY=1, X={7}, Y={9}, start at cycle 0 -> writeZ at cycle 3 with addr 0, data 63; done at cycle 4; busy high during cycles 1-3.
- sizeX=sizeY=31, all X=Y=255 -> 61 writes.
  - Z[0] = 0xFE01.
  - Z[1] = 0xFFFF (saturated, raw 130050).
  - Z[30] = 0xFFFF.
  - Z[60] = 0xFE01.
  - Last write at addr 60.
- sizeY=0 with sizeX=4, start -> no writeZ ever; done pulse exactly 1 cycle after IDLE samples start.
- Start the 3x2 case, then assert start again with sizeX=1 during MAC -> second start ignored; results match the first test exactly.
- Start the 31x31 case, pulse rstn low during the 5th WRITE -> all outputs 0 immediately; no done pulse. Then a new start with the 3x2 case -> correct results from addr 0.
